// File: rtl/uart_tx_word_if.sv
// Word-transmit bus for uart_tx_word.
//
// Handshake: i_tx_en is the request (valid) and !o_tx_busy is the ready.
// A request is taken on the rising edge where i_tx_en=1 and the transmitter
// is idle. i_tx_data is sampled on that same edge only. A request seen
// while busy is dropped, not queued. The requester must hold or re-assert
// i_tx_en until it sees o_tx_busy rise.
// dbg_state mirrors the transmitter FSM state for checkers:
// 0=IDLE, 1=START, 2=DATA, 3=STOP.
interface uart_tx_word_if #(
  parameter int SIZE_DATA = 32
);
  logic                 i_tx_en;
  logic [SIZE_DATA-1:0] i_tx_data;
  logic                 o_tx_serial;
  logic                 o_tx_busy;
  logic                 o_byte_done;
  logic                 o_tx_done;
  logic [1:0]           dbg_state;

  modport master (
    output i_tx_en,
    output i_tx_data,
    input  o_tx_serial,
    input  o_tx_busy,
    input  o_byte_done,
    input  o_tx_done,
    input  dbg_state
  );

  modport slave (
    input  i_tx_en,
    input  i_tx_data,
    output o_tx_serial,
    output o_tx_busy,
    output o_byte_done,
    output o_tx_done,
    output dbg_state
  );
endinterface

// File: rtl/uart_tx_word.sv
// UART 8N1 transmitter for a multi-byte word, least-significant byte first.
// Each byte is framed as a start bit, 8 data bits (LSB first) and a stop bit.
// Every bit lasts BAUDRATE_VALUE clocks. Consecutive bytes of one word are
// sent back to back, so the stop bit of one byte is followed directly by
// the start bit of the next. Every output is a flop.
module uart_tx_word #(
  parameter int SIZE_DATA      = 32,
  parameter int BAUDRATE_VALUE = 325
) (
  input  logic           i_clk,
  input  logic           i_rst,
  uart_tx_word_if.slave  bus
);

  localparam int NUM_BYTES = SIZE_DATA / 8;
  localparam int BAUD_W    = $clog2(BAUDRATE_VALUE);
  localparam int BYTE_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUDRATE_VALUE - 1);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [2:0]           bit_cnt;
  logic [BYTE_W-1:0]    byte_idx;
  logic [SIZE_DATA-1:0] shift_reg;
  logic                 serial;
  logic                 busy;
  logic                 byte_done;
  logic                 tx_done;
  logic                 baud_last;

  // The current bit has been on the line for its full period.
  assign baud_last = (baud_cnt == BAUD_LAST);

  // Framing FSM. It owns every counter and every registered output.
  // The shift register moves right once per data bit. After 8 shifts the
  // next byte of the word sits in shift_reg[7:0].
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shift_reg <= '0;
      serial    <= 1'b1;
      busy      <= 1'b0;
      byte_done <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      byte_done <= 1'b0;
      tx_done   <= 1'b0;
      unique case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (bus.i_tx_en) begin
            shift_reg <= bus.i_tx_data;
            byte_idx  <= '0;
            serial    <= 1'b0;
            busy      <= 1'b1;
            state     <= START;
          end else begin
            serial <= 1'b1;
            busy   <= 1'b0;
          end
        end

        START: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            serial    <= shift_reg[0];
            shift_reg <= {1'b0, shift_reg[SIZE_DATA-1:1]};
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              serial <= 1'b1;
              state  <= STOP;
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              serial    <= shift_reg[0];
              shift_reg <= {1'b0, shift_reg[SIZE_DATA-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        STOP: begin
          if (baud_last) begin
            baud_cnt  <= '0;
            byte_done <= 1'b1;
            if (byte_idx == BYTE_LAST) begin
              // The last stop bit ends in the same cycle as the return to IDLE.
              tx_done <= 1'b1;
              busy    <= 1'b0;
              serial  <= 1'b1;
              state   <= IDLE;
            end else begin
              // The next byte starts at once. There is no idle gap between
              // bytes of one word.
              byte_idx <= byte_idx + BYTE_W'(1);
              serial   <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state  <= IDLE;
          serial <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_tx_serial = serial;
  assign bus.o_tx_busy   = busy;
  assign bus.o_byte_done = byte_done;
  assign bus.o_tx_done   = tx_done;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_uart_tx_word.sv
// Bench for uart_tx_word.
// Two instances run side by side:
//   - dut  uses a baud divisor of 325.
//   - dut4 uses a baud divisor of 4, to check byte pacing.
// A frame-level model predicts the line every cycle. Directed cases check
// the outputs against hand-computed literals.
module tb_uart_tx_word;

  localparam int  NB    = 4;
  localparam int  B0    = 325;
  localparam int  B1    = 4;
  localparam longint TOT0 = NB * 10 * B0;
  localparam longint TOT1 = NB * 10 * B1;

  logic clk = 1'b0;
  logic rst0;
  logic rst1;
  bit   started = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  uart_tx_word_if #(.SIZE_DATA(32)) bus0 ();
  uart_tx_word_if #(.SIZE_DATA(32)) bus1 ();

  uart_tx_word #(.SIZE_DATA(32), .BAUDRATE_VALUE(B0)) dut (
    .i_clk (clk),
    .i_rst (rst0),
    .bus   (bus0)
  );

  uart_tx_word #(.SIZE_DATA(32), .BAUDRATE_VALUE(B1)) dut4 (
    .i_clk (clk),
    .i_rst (rst1),
    .bus   (bus1)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The line is computed from the frame rules.
  // t is the number of clock edges since the capture edge.
  // The result is {serial, busy, byte_done, tx_done}.
  function automatic logic [3:0] model_out(input logic [31:0] word, input int baud,
                                           input bit active, input longint t);
    longint total;
    longint byte_i;
    longint bit_i;
    logic   s;
    logic   bd;
    total = longint'(NB) * 10 * baud;
    if (!active || t > total) return 4'b1000;
    if (t == total) return 4'b1011;
    byte_i = t / (10 * baud);
    bit_i  = (t / baud) % 10;
    if (bit_i == 0)      s = 1'b0;
    else if (bit_i == 9) s = 1'b1;
    else                 s = word[int'(byte_i * 8 + bit_i - 1)];
    bd = (t > 0) && (t % (10 * baud) == 0);
    return {s, 1'b1, bd, 1'b0};
  endfunction

  // Model state for each instance.
  bit          act0 = 1'b0;
  longint      t0   = 0;
  logic [31:0] w0   = '0;
  bit          act1 = 1'b0;
  longint      t1   = 0;
  logic [31:0] w1   = '0;

  always @(posedge clk or posedge rst0) begin
    if (rst0) begin
      act0 <= 1'b0;
      t0   <= 0;
    end else if ((!act0 || t0 >= TOT0) && bus0.i_tx_en) begin
      act0 <= 1'b1;
      t0   <= 0;
      w0   <= bus0.i_tx_data;
    end else begin
      t0 <= t0 + 1;
    end
  end

  always @(posedge clk or posedge rst1) begin
    if (rst1) begin
      act1 <= 1'b0;
      t1   <= 0;
    end else if ((!act1 || t1 >= TOT1) && bus1.i_tx_en) begin
      act1 <= 1'b1;
      t1   <= 0;
      w1   <= bus1.i_tx_data;
    end else begin
      t1 <= t1 + 1;
    end
  end

  // Compare process. It checks every cycle, on the falling edge.
  logic [3:0] e0;
  logic [3:0] e1;
  always @(negedge clk) begin
    if (started) begin
      e0 = model_out(w0, B0, act0, t0);
      check("m0_serial", bus0.o_tx_serial, e0[3]);
      check("m0_busy",   bus0.o_tx_busy,   e0[2]);
      check("m0_bdone",  bus0.o_byte_done, e0[1]);
      check("m0_tdone",  bus0.o_tx_done,   e0[0]);
      e1 = model_out(w1, B1, act1, t1);
      check("m1_serial", bus1.o_tx_serial, e1[3]);
      check("m1_busy",   bus1.o_tx_busy,   e1[2]);
      check("m1_bdone",  bus1.o_byte_done, e1[1]);
      check("m1_tdone",  bus1.o_tx_done,   e1[0]);
    end
  end

  // Driver: a one-cycle request on bus0. The task returns #1 after the
  // capture edge. It then scrambles i_tx_data to show that the word was
  // latched at capture.
  task automatic send_word(input logic [31:0] w);
    @(posedge clk);
    #2;
    bus0.i_tx_en   = 1'b1;
    bus0.i_tx_data = w;
    @(posedge clk);
    #1;
    bus0.i_tx_en   = 1'b0;
    bus0.i_tx_data = ~w;
    check("start_latency_serial", bus0.o_tx_serial, 1'b0);
    check("start_latency_busy",   bus0.o_tx_busy,   1'b1);
  endtask

  // Watch bus0 for stop_n edges after capture.
  // It samples each bit at mid-period, counts tx_done pulses, and can
  // inject one request while the transmitter is busy.
  task automatic watch(input int stop_n, input int inject_n, input logic [31:0] inj,
                       output int done_at, output int done_cnt,
                       output logic [31:0] rx_word, output logic [9:0] frame0);
    logic [39:0] bits;
    bits     = '1;
    done_at  = -1;
    done_cnt = 0;
    for (int n = 1; n <= stop_n; n++) begin
      @(posedge clk);
      #1;
      if (n == inject_n + 1) begin
        bus0.i_tx_en   = 1'b0;
        bus0.i_tx_data = 32'h0;
      end
      if (n == inject_n) begin
        bus0.i_tx_en   = 1'b1;
        bus0.i_tx_data = inj;
      end
      if (n >= B0 / 2 && (n - B0 / 2) % B0 == 0 && (n - B0 / 2) / B0 < 40)
        bits[(n - B0 / 2) / B0] = bus0.o_tx_serial;
      if (bus0.o_tx_done) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
    end
    for (int k = 0; k < NB; k++) rx_word[k*8 +: 8] = bits[k*10 + 1 +: 8];
    frame0 = bits[9:0];
  endtask

  // Pop the expected bytes from exp_q and compare them with a received word.
  task automatic check_bytes(input string name, input logic [31:0] rx);
    logic [7:0] e;
    for (int k = 0; k < NB; k++) begin
      if (exp_q.size() == 0) begin
        check({name, "_queue_empty"}, 1, 0);
      end else begin
        e = exp_q.pop_front();
        check(name, rx[k*8 +: 8], e);
      end
    end
  endtask

  int          done_at;
  int          done_cnt;
  logic [31:0] rx_word;
  logic [9:0]  frame0;
  int          low_cnt;
  int          idle_done;

  initial begin
    rst0 = 1'b0;
    rst1 = 1'b0;
    bus0.i_tx_en = 1'b0;
    bus0.i_tx_data = '0;
    bus1.i_tx_en = 1'b0;
    bus1.i_tx_data = '0;
    #1;
    rst0 = 1'b1;
    rst1 = 1'b1;
    started = 1'b1;
    #1;
    check("reset_serial", bus0.o_tx_serial, 1'b1);
    check("reset_busy",   bus0.o_tx_busy,   1'b0);
    check("reset_state",  bus0.dbg_state,   2'd0);
    repeat (3) @(posedge clk);
    #2;
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_line_high", bus0.o_tx_serial, 1'b1);

    // Word transfer: bytes A6, C0, B0, C0. tx_done must come 13000 edges
    // after capture.
    send_word(32'hC0B0C0A6);
    watch(13000, -1, 32'h0, done_at, done_cnt, rx_word, frame0);
    check("w1_first_frame", frame0, 10'b1101001100);
    check("w1_done_at",     done_at, 13000);
    check("w1_done_cnt",    done_cnt, 1);
    check("w1_loopback",    rx_word, 32'hC0B0C0A6);
    exp_q.push_back(8'hA6);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hC0);
    check_bytes("w1_byte", rx_word);
    repeat (3) @(posedge clk);

    // A request while busy must be ignored.
    send_word(32'hC0B0C0A6);
    watch(13050, 5000, 32'h12345678, done_at, done_cnt, rx_word, frame0);
    check("ign_done_at",  done_at, 13000);
    check("ign_done_cnt", done_cnt, 1);
    exp_q.push_back(8'hA6);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hB0);
    exp_q.push_back(8'hC0);
    check_bytes("ign_byte", rx_word);

    // Back-to-back: a new request is made in the cycle tx_done is high.
    send_word(32'hC0B0C0A6);
    watch(13000, -1, 32'h0, done_at, done_cnt, rx_word, frame0);
    check("b2b_done_pulse", bus0.o_tx_done,   1'b1);
    check("b2b_done_line",  bus0.o_tx_serial, 1'b1);
    bus0.i_tx_en   = 1'b1;
    bus0.i_tx_data = 32'h3F800000;
    @(posedge clk);
    #1;
    bus0.i_tx_en   = 1'b0;
    bus0.i_tx_data = 32'hDEADBEEF;
    check("b2b_start_serial", bus0.o_tx_serial, 1'b0);
    check("b2b_start_busy",   bus0.o_tx_busy,   1'b1);
    watch(13000, -1, 32'h0, done_at, done_cnt, rx_word, frame0);
    check("b2b_done_at", done_at, 13000);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'h3F);
    check_bytes("b2b_byte", rx_word);
    repeat (3) @(posedge clk);

    // Reset in mid-word, asserted between clock edges.
    send_word(32'hA5A5A5A5);
    watch(2000, -1, 32'h0, done_at, done_cnt, rx_word, frame0);
    #3;
    rst0 = 1'b1;
    #1;
    check("rst_async_serial", bus0.o_tx_serial, 1'b1);
    check("rst_async_busy",   bus0.o_tx_busy,   1'b0);
    check("rst_async_state",  bus0.dbg_state,   2'd0);
    repeat (2) @(posedge clk);
    #2;
    rst0 = 1'b0;
    low_cnt   = 0;
    idle_done = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      if (!bus0.o_tx_serial) low_cnt++;
      if (bus0.o_tx_done)    idle_done++;
    end
    check("rst_line_stays_high", low_cnt, 0);
    check("rst_no_done",         idle_done, 0);
    send_word(32'h000000FF);
    watch(13000, -1, 32'h0, done_at, done_cnt, rx_word, frame0);
    check("post_rst_done_at", done_at, 13000);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    check_bytes("post_rst_byte", rx_word);

    // Byte pacing with a divisor of 4. Each byte takes 40 cycles.
    @(posedge clk);
    #2;
    bus1.i_tx_en   = 1'b1;
    bus1.i_tx_data = 32'h00000000;
    @(posedge clk);
    #1;
    bus1.i_tx_en   = 1'b0;
    bus1.i_tx_data = 32'hFFFFFFFF;
    for (int n = 1; n <= 170; n++) begin
      @(posedge clk);
      #1;
      check("pace_byte_done", bus1.o_byte_done, (n % 40 == 0) && (n <= 160));
      check("pace_tx_done",   bus1.o_tx_done,   n == 160);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_word.md
UART_TX_WORD -- requirements
Module: uart_tx_word

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 32, meaning word width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter BAUDRATE_VALUE, default 325, meaning i_clk cycles per UART bit; legal values are 2 or greater.
REQ-003 SHALL have port i_clk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port i_tx_en, input, 1 bit: start request, sampled on the i_clk rising edge.
REQ-006 SHALL have port i_tx_data, input, SIZE_DATA bits: word to transmit, sampled with i_tx_en.
REQ-007 SHALL have port o_tx_serial, output, 1 bit: UART line, 8N1, idle high.
REQ-008 SHALL have port o_tx_busy, output, 1 bit: high while a word is in flight.
REQ-009 SHALL have port o_byte_done, output, 1 bit: one-cycle pulse at the end of each byte's stop bit.
REQ-010 SHALL have port o_tx_done, output, 1 bit: one-cycle pulse at the end of the word's last stop bit.

Function
REQ-011 SHALL implement the states IDLE, START, DATA and STOP.
REQ-012 In IDLE with i_tx_en=1, SHALL latch i_tx_data into a shift register, clear the byte index to 0 and go to START.
REQ-013 In IDLE, o_tx_busy SHALL be 0.
REQ-014 In START, DATA and STOP, o_tx_busy SHALL be 1.
REQ-015 o_tx_serial SHALL drop to 0 in the first cycle after the capture edge, giving 1 cycle of start latency.
REQ-016 Each state SHALL hold for exactly BAUDRATE_VALUE cycles per bit, using a baud counter that counts from 0 to BAUDRATE_VALUE-1 and reloads to 0 on every bit boundary.
REQ-017 START SHALL drive 0 on o_tx_serial.
REQ-018 DATA SHALL drive 8 bits, LSB first, using a 3-bit bit counter.
REQ-019 STOP SHALL drive 1 on o_tx_serial.
REQ-020 Bytes SHALL be sent least-significant byte first: i_tx_data[7:0], then [15:8], and so on up to byte SIZE_DATA/8-1.
REQ-021 At the end of STOP with more bytes remaining, SHALL pulse o_byte_done, advance the byte index and enter START directly, with no idle gap.
REQ-022 At the end of STOP for the last byte, SHALL pulse o_byte_done and o_tx_done in the same cycle as the return to IDLE.
REQ-023 Total busy time SHALL be (SIZE_DATA/8)*10*BAUDRATE_VALUE cycles.
REQ-024 i_tx_en while busy SHALL be ignored; the latched word and timing SHALL be unaffected.
REQ-025 Changes on i_tx_data after capture SHALL NOT affect the transmission.
REQ-026 i_tx_en=1 in the cycle o_tx_done pulses (state IDLE) SHALL be accepted.
REQ-027 A word accepted as in REQ-026 SHALL begin its start bit on the next cycle, so the stop-to-start boundary has no extra idle cycle.
REQ-028 While i_tx_en is held high continuously, SHALL start a new word after each completion, re-sampling i_tx_data each time.
REQ-029 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-030 On i_rst=1, the block SHALL immediately (asynchronously) set state to IDLE.
REQ-031 On i_rst=1, the baud, bit and byte counters and the shift register SHALL clear to 0.
REQ-032 On i_rst=1, o_tx_serial SHALL go to 1, and o_tx_busy, o_byte_done and o_tx_done SHALL go to 0.
REQ-033 Reset mid-word SHALL abort the transfer without a done pulse.
REQ-034 After reset deasserts, the line SHALL stay high until a new i_tx_en.

Verification
REQ-035 Word transfer: BAUDRATE_VALUE=325, send 32'hC0B0C0A6. Required response:
  - byte order A6, C0, B0, C0;
  - first frame 0,0,1,1,0,0,1,0,1,1, each bit 325 cycles;
  - o_tx_done exactly 13000 cycles after the capture edge.
  A loopback through the existing receiver (SIZE_DATA=32) SHALL yield 32'hC0B0C0A6.
REQ-036 Ignored request: pulse i_tx_en with 32'h12345678 at cycle 5000 of a transfer of 32'hC0B0C0A6. Required response: the serial stream is unchanged, and o_tx_done occurs once.
REQ-037 Back-to-back: re-assert i_tx_en with 32'h3F800000 in the o_tx_done cycle. Required response: the start bit begins on the next cycle, and the bytes are 00, 00, 80, 3F.
REQ-038 Reset mid-word: assert i_rst at cycle 2000 of a transfer, asynchronously between clock edges. Required response:
  - o_tx_serial=1 and o_tx_busy=0 before the next edge;
  - no o_tx_done pulse;
  - a subsequent 32'h000000FF sends cleanly.
REQ-039 Byte pacing: send 32'h00000000 with BAUDRATE_VALUE=4. Required response: o_byte_done pulses at cycles 40, 80, 120 and 160 after capture; o_tx_done pulses at 160 only.
